// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage: butterfly with a D-deep
// feedback FIFO, frame counter with flush, registered outputs.
//
// Ports:
//   iClk, iRst                  clock, synchronous active-high reset
//   iData_valid                 input sample valid
//   iData_Re, iData_Im          input sample (DATA_W bits, signed)
//   oData_valid                 output sample valid
//   oData_Re, oData_Im          output sample (DATA_W+1 bits, signed)
//   oFrame_start                pulse with first valid output of a frame
//
// Macro R2SDF_STAGE_SCALE_EN: when defined, outputs are rounded as
// (x+1)>>>1; the feedback buffer always keeps full precision.
module r2sdf_stage #(
    parameter int DATA_W     = 37,
    parameter int DELAY_LOG2 = 0,
    parameter int FFT_LOG2   = 7
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iData_valid,
    input  logic signed [DATA_W-1:0] iData_Re,
    input  logic signed [DATA_W-1:0] iData_Im,
    output logic                     oData_valid,
    output logic signed [DATA_W:0]   oData_Re,
    output logic signed [DATA_W:0]   oData_Im,
    output logic                     oFrame_start
);

    localparam int OW    = DATA_W + 1;
    localparam int CW    = FFT_LOG2 + 1;
    localparam int DEPTH = 1 << DELAY_LOG2;

    localparam logic [CW-1:0] D_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST  = CW'((1 << FFT_LOG2) + DEPTH - 1);

    logic [CW-1:0] cnt;
    logic          flush;
    logic          en;
    logic          bfly;

    logic signed [OW-1:0] dly_re [DEPTH];
    logic signed [OW-1:0] dly_im [DEPTH];

    logic signed [OW-1:0] in_re,  in_im;
    logic signed [OW-1:0] head_re, head_im;
    logic signed [OW-1:0] wr_re,  wr_im;
    logic signed [OW-1:0] res_re, res_im;
    logic                 valid_nxt;
    logic                 fs_nxt;

`ifdef R2SDF_STAGE_SCALE_EN
    // Round half up: add one in a one-bit-wider word, then drop the LSB.
    function automatic logic signed [OW-1:0] scale(input logic signed [OW-1:0] x);
        logic signed [OW:0] t;
        t = {x[OW-1], x} + 1'b1;
        return t[OW:1];
    endfunction
`else
    function automatic logic signed [OW-1:0] scale(input logic signed [OW-1:0] x);
        return x;
    endfunction
`endif

    assign flush = cnt[FFT_LOG2];
    assign en    = iData_valid | flush;
    assign bfly  = cnt[DELAY_LOG2];

    // Flush cycles push zeros so stale input never enters the buffer.
    assign in_re = flush ? '0 : OW'(iData_Re);
    assign in_im = flush ? '0 : OW'(iData_Im);

    assign head_re = dly_re[DEPTH-1];
    assign head_im = dly_im[DEPTH-1];

    // In the butterfly phase the head always holds a fill-phase sample,
    // so head +/- input fits in OW bits without wrap.
    always_comb begin
        wr_re  = in_re;
        wr_im  = in_im;
        res_re = head_re;
        res_im = head_im;
        if (bfly) begin
            wr_re  = head_re - in_re;
            wr_im  = head_im - in_im;
            res_re = head_re + in_re;
            res_im = head_im + in_im;
        end
    end

    assign valid_nxt = flush |
        (iData_valid & (cnt[FFT_LOG2-1:0] >= D_CNT[FFT_LOG2-1:0]));
    assign fs_nxt = iData_valid & ~flush & (cnt == D_CNT);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt          <= '0;
            oData_valid  <= 1'b0;
            oFrame_start <= 1'b0;
            oData_Re     <= '0;
            oData_Im     <= '0;
        end else begin
            oData_valid  <= valid_nxt;
            oFrame_start <= fs_nxt;
            if (valid_nxt) begin
                oData_Re <= scale(res_re);
                oData_Im <= scale(res_im);
            end
            if (en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Shift-register FIFO; contents are don't-care after reset because
    // the fill phase rewrites every entry before it is read.
    always_ff @(posedge iClk) begin
        if (en) begin
            dly_re[0] <= wr_re;
            dly_im[0] <= wr_im;
            for (int i = 1; i < DEPTH; i++) begin
                dly_re[i] <= dly_re[i-1];
                dly_im[i] <= dly_im[i-1];
            end
        end
    end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Self-checking bench for r2sdf_stage (DATA_W=8, D=2, N=8).
// Frame-level butterfly model feeds an expected-output queue.
module tb_r2sdf_stage;

    localparam int DW = 8;
    localparam int DL = 1;
    localparam int FL = 3;
    localparam int D  = 1 << DL;
    localparam int N  = 1 << FL;

    logic                 iClk = 1'b0;
    logic                 iRst;
    logic                 iData_valid;
    logic signed [DW-1:0] iData_Re;
    logic signed [DW-1:0] iData_Im;
    logic                 oData_valid;
    logic signed [DW:0]   oData_Re;
    logic signed [DW:0]   oData_Im;
    logic                 oFrame_start;

    r2sdf_stage #(.DATA_W(DW), .DELAY_LOG2(DL), .FFT_LOG2(FL)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iData_valid(iData_valid),
        .iData_Re(iData_Re),
        .iData_Im(iData_Im),
        .oData_valid(oData_valid),
        .oData_Re(oData_Re),
        .oData_Im(oData_Im),
        .oFrame_start(oFrame_start)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int re;
        int im;
        bit fs;
    } exp_t;

    exp_t expq[$];
    int   rx_re[$];
    int   rx_im[$];
    int   rx_cyc[$];
    bit   rx_fs[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sc(input int x);
`ifdef R2SDF_STAGE_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    // Radix-2 DIF split: per block of 2D samples emit D sums, then D diffs.
    function automatic void model_frame(input int re[N], input int im[N],
                                        ref exp_t q[$]);
        for (int b = 0; b < N; b += 2 * D) begin
            for (int j = 0; j < D; j++)
                q.push_back('{sc(re[b+j] + re[b+D+j]),
                              sc(im[b+j] + im[b+D+j]),
                              (b == 0 && j == 0)});
            for (int j = 0; j < D; j++)
                q.push_back('{sc(re[b+j] - re[b+D+j]),
                              sc(im[b+j] - im[b+D+j]), 1'b0});
        end
    endfunction

    always @(negedge iClk) begin
        exp_t e;
        cyc++;
        if (oData_valid) begin
            rx_re.push_back(int'(oData_Re));
            rx_im.push_back(int'(oData_Im));
            rx_cyc.push_back(cyc);
            rx_fs.push_back(oFrame_start);
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("out_re", int'(oData_Re), e.re);
                chk("out_im", int'(oData_Im), e.im);
                chk("frame_start", int'(oFrame_start), int'(e.fs));
            end
        end else begin
            chk("fs_without_valid", int'(oFrame_start), 0);
        end
    end

    task automatic idle(input int n, input bit junk);
        iData_valid = junk;
        iData_Re    = 8'sd55;
        iData_Im    = -8'sd55;
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
        iData_valid = 1'b0;
    endtask

    task automatic send(input int re, input int im);
        iData_valid = 1'b1;
        iData_Re    = DW'(re);
        iData_Im    = DW'(im);
        @(posedge iClk);
        #1;
        iData_valid = 1'b0;
    endtask

    task automatic run_frame(input int re[N], input int im[N],
                             input int gap_after, input int gap_len,
                             input bit junk);
        model_frame(re, im, expq);
        for (int i = 0; i < N; i++) begin
            send(re[i], im[i]);
            if (i == gap_after) idle(gap_len, 1'b0);
        end
        idle(D, junk);
    endtask

    task automatic clear_rx();
        rx_re.delete();
        rx_im.delete();
        rx_cyc.delete();
        rx_fs.delete();
    endtask

    task automatic drain();
        idle(3, 1'b0);
        chk("leftover", expq.size(), 0);
    endtask

    int f1[N]    = '{1, 2, 3, 4, 5, 6, 7, 8};
    int f2[N]    = '{3, -1, 4, 1, -5, 9, 2, -6};
    int zr[N]    = '{default: 0};
    int p127[N]  = '{default: 127};
    int m128[N]  = '{default: -128};
`ifdef R2SDF_STAGE_SCALE_EN
    int lit1[N]  = '{2, 3, -1, -1, 6, 7, -1, -1};
    int lit_pos  = 127;
    int lit_neg  = -128;
`else
    int lit1[N]  = '{4, 6, -2, -2, 12, 14, -2, -2};
    int lit_pos  = 254;
    int lit_neg  = -256;
`endif

    initial begin
        exp_t pin[$];
        int   nfs;
        iRst        = 1'b1;
        iData_valid = 1'b0;
        iData_Re    = '0;
        iData_Im    = '0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        @(negedge iClk);
        chk("rst_valid", int'(oData_valid), 0);
        chk("rst_re", int'(oData_Re), 0);
        chk("rst_im", int'(oData_Im), 0);
        chk("rst_fs", int'(oFrame_start), 0);

        model_frame(f1, zr, pin);
        chk("model_len", pin.size(), N);
        for (int i = 0; i < N; i++)
            chk("model_lit", pin[i].re, lit1[i]);

        // basic frame
        @(posedge iClk);
        #1;
        clear_rx();
        run_frame(f1, zr, -1, 0, 1'b0);
        drain();
        chk("s1_count", rx_re.size(), N);
        for (int i = 0; i < N && i < rx_re.size(); i++)
            chk("s1_lit", rx_re[i], lit1[i]);
        if (rx_re.size() == N) begin
            chk("s1_span", rx_cyc[N-1] - rx_cyc[0], N - 1);
            chk("s1_fs0", int'(rx_fs[0]), 1);
        end

        // input gap of 3 after sample 3
        clear_rx();
        run_frame(f1, zr, 2, 3, 1'b0);
        drain();
        chk("s2_count", rx_re.size(), N);
        for (int i = 0; i < N && i < rx_re.size(); i++)
            chk("s2_lit", rx_re[i], lit1[i]);
        if (rx_re.size() == N)
            chk("s2_span", rx_cyc[N-1] - rx_cyc[0], N - 1 + 3);

        // back-to-back frames, junk valid during first flush
        clear_rx();
        run_frame(f1, zr, -1, 0, 1'b1);
        run_frame(f2, f1, -1, 0, 1'b0);
        drain();
        chk("s3_count", rx_re.size(), 2 * N);
        nfs = 0;
        foreach (rx_fs[i]) nfs += int'(rx_fs[i]);
        chk("s3_nfs", nfs, 2);
        if (rx_re.size() == 2 * N) begin
            chk("s3_fs8", int'(rx_fs[N]), 1);
            chk("s3_span", rx_cyc[2*N-1] - rx_cyc[0], 2 * N + 1);
        end

        // full-scale sums, no wrap
        clear_rx();
        run_frame(p127, m128, -1, 0, 1'b0);
        run_frame(m128, m128, -1, 0, 1'b0);
        drain();
        if (rx_re.size() == 2 * N) begin
            chk("s4_pos_re", rx_re[0], lit_pos);
            chk("s4_pos_im", rx_im[0], lit_neg);
            chk("s4_neg_re", rx_re[N], lit_neg);
        end else begin
            chk("s4_count", rx_re.size(), 2 * N);
        end

        // reset mid-frame, then fresh frame
        model_frame(f1, zr, expq);
        for (int i = 0; i < 5; i++) send(f1[i], 0);
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        expq.delete();
        chk("mid_rst_valid", int'(oData_valid), 0);
        chk("mid_rst_re", int'(oData_Re), 0);
        iRst = 1'b0;
        idle(2, 1'b0);
        chk("post_rst_re", int'(oData_Re), 0);
        clear_rx();
        run_frame(f1, zr, -1, 0, 1'b0);
        drain();
        chk("s5_count", rx_re.size(), N);
        for (int i = 0; i < N && i < rx_re.size(); i++)
            chk("s5_lit", rx_re[i], lit1[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/r2sdf_stage.md
R2SDF_STAGE -- requirements
Module: r2sdf_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 37, meaning input sample width per component (two's complement).
REQ-002 The block SHALL have parameter DELAY_LOG2, default 0, meaning feedback delay D = 2^DELAY_LOG2 samples.
REQ-003 The block SHALL have parameter FFT_LOG2, default 7, meaning frame length N = 2^FFT_LOG2; DELAY_LOG2 < FFT_LOG2 is required.
REQ-004 The block SHALL have port iClk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iRst, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port iData_valid, input, 1 bit, meaning the input sample is valid this cycle.
REQ-007 The block SHALL have ports iData_Re and iData_Im, input, DATA_W bits each, meaning the input sample.
REQ-008 The block SHALL have port oData_valid, output, 1 bit, meaning the output sample is valid.
REQ-009 The block SHALL have ports oData_Re and oData_Im, output, DATA_W+1 bits each, meaning the output sample.
REQ-010 The block SHALL have port oFrame_start, output, 1 bit, meaning a pulse with the first valid output of each frame.

Function
REQ-011 The block SHALL keep a counter cnt of FFT_LOG2+1 bits; flush = cnt[FFT_LOG2]; En = iData_valid | flush; cnt increments only when En = 1.
REQ-012 When En = 1 and cnt = N+D-1, cnt SHALL wrap to 0 on the next edge instead of incrementing.
REQ-013 The delay buffer SHALL be D entries of complex (DATA_W+1)-bit samples, FIFO-ordered; it advances (one write, one read) only when En = 1 and holds otherwise.
REQ-014 Fill phase (cnt[DELAY_LOG2] = 0): the buffer SHALL load the sign-extended input, and the output SHALL be the buffer head.
REQ-015 Butterfly phase (cnt[DELAY_LOG2] = 1): the output SHALL be head + input, and the buffer SHALL load head - input, with all arithmetic sign-extended to DATA_W+1 bits and no wrap.
REQ-016 During flush the input value SHALL be ignored; because D < N, flush always falls in the fill phase.
REQ-017 oData_valid SHALL be registered as flush | (iData_valid & cnt[FFT_LOG2-1:0] >= D).
REQ-018 oFrame_start SHALL be registered as iData_valid & ~flush & cnt = D.
REQ-019 Outputs SHALL be registered with latency exactly 1 cycle from the En cycle; when oData_valid = 0, output data holds its last value.
REQ-020 Gaps in iData_valid (outside flush) SHALL stall cnt and the buffer with no data loss.
REQ-021 If iData_valid asserts during flush, the sample SHALL be ignored (not counted); a new frame starts only after the wrap.

Reset
REQ-022 When iRst = 1 at an edge, cnt, oData_valid, oFrame_start, oData_Re and oData_Im SHALL all become 0; buffer contents need not be cleared.
REQ-023 A reset mid-frame SHALL abandon the frame; the first valid input after reset is treated as sample 0 of a new frame.

Configuration
REQ-024 Macro R2SDF_STAGE_SCALE_EN SHALL control output scaling.
  - Defined: every output value (head, sum) is rounded as (x+1)>>>1, arithmetic shift, then sign-extended to DATA_W+1 bits; buffer contents remain unscaled.
  - Undefined: the output is the full-precision DATA_W+1-bit value.

Verification
(All scenarios use DATA_W=8, DELAY_LOG2=1, FFT_LOG2=3, with Im=0 unless stated.)
REQ-025 Re inputs 1..8 on 8 consecutive cycles -> valid Re outputs 4, 6, -2, -2, 12, 14, -2, -2 on consecutive cycles, the last two in flush; oFrame_start high with the "4"; valid low otherwise.
REQ-026 Same as REQ-025 with iData_valid low for 3 cycles after sample 3 -> identical output sequence, stalled 3 cycles, no corruption.
REQ-027 Two back-to-back frames with the second starting the cycle after the wrap -> 16 valid outputs, with oFrame_start pulsing twice, 8 valid outputs apart.
REQ-028 Re inputs all 127, then all -128 (both with Im=-128) -> sums 254 and -256 appear unwrapped on the 9-bit ports.
REQ-029 iRst asserted after sample 5 of a frame, then a fresh frame 1..8 -> outputs 0 during and after reset, then the same sequence as REQ-025.
REQ-030 R2SDF_STAGE_SCALE_EN defined, with the REQ-025 stimulus -> outputs 2, 3, -1, -1, 6, 7, -1, -1.
